sdram_timing_engine: RTL and testbench

//  Parametrised SDRAM timing engine that supersedes the single-counter delay generator.
//  - One command-delay down-counter.
//  - NUM_BANKS per-bank row-cycle busy timers.
//  - Mode-register decode (burst length, CAS latency) and programmable timing registers.
//  - Sits between the SDRAM controller FSM (loads timers, waits on done/busy) and the command/data path.

---
 rtl/sdram_pkg.sv | 18 +
 rtl/sdram_down_counter.sv | 36 +++
 rtl/sdram_timing_engine.sv | 151 +++++++++++++++
 tb/tb_sdram_timing_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared codes and constants for the SDRAM timing engine.
package sdram_pkg;

    localparam logic [2:0] LD_TRP    = 3'd0;
    localparam logic [2:0] LD_TWAIT  = 3'd1;
    localparam logic [2:0] LD_TCAS   = 3'd2;
    localparam logic [2:0] LD_TBURST = 3'd3;
    localparam logic [2:0] LD_TRCD   = 3'd4;

    localparam logic [1:0] CFG_TRP   = 2'd0;
    localparam logic [1:0] CFG_TWAIT = 2'd1;
    localparam logic [1:0] CFG_TRCD  = 2'd2;
    localparam logic [1:0] CFG_TRC   = 2'd3;

    localparam logic [2:0] BL_FULL   = 3'b111;
    localparam int         CAS_OFFSET = 2;

endpackage

// File: rtl/sdram_down_counter.sv
// Loadable saturating down-counter with a registered pulse on the 1->0 step.
module sdram_down_counter #(
    parameter int               CNT_W   = 10,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic [CNT_W-1:0] o_count,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;
    logic             r_done;

    // Load wins over the decrement, so a reload at count 1 never pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RST_VAL;
            r_done  <= 1'b0;
        end else if (i_load) begin
            r_count <= i_value;
            r_done  <= 1'b0;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
            r_done  <= (r_count == CNT_W'(1));
        end else begin
            r_done  <= 1'b0;
        end
    end

    assign o_count = r_count;
    assign o_done  = r_done;

endmodule

// File: rtl/sdram_timing_engine.sv
// SDRAM timing engine: command delay counter, per-bank tRC timers, mode decode.
// Optional refresh interval timer enabled by SDRAM_TIMING_REFRESH_TIMER_EN.
module sdram_timing_engine
    import sdram_pkg::*;
#(
    parameter int CNT_W     = 10,
    parameter int NUM_BANKS = 4,
    parameter int TRP_DEF   = 3,
    parameter int TWAIT_DEF = 3,
    parameter int TRCD_DEF  = 3,
    parameter int TRC_DEF   = 7,
    parameter int TREF_DEF  = 780
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode_we,
    input  logic [CNT_W-1:0]     prog_data,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_addr,
    input  logic [CNT_W-1:0]     cfg_data,
    input  logic                 load_req,
    input  logic [2:0]           load_sel,
    input  logic [NUM_BANKS-1:0] bank_load,
    output logic [CNT_W-1:0]     count_out,
    output logic                 cmd_done,
    output logic [CNT_W-1:0]     tburst,
    output logic [2:0]           tlat,
    output logic [NUM_BANKS-1:0] bank_busy,
    output logic                 mode_err,
    output logic                 ref_req,
    input  logic                 ref_ack
);

    logic [CNT_W-1:0] r_trp, r_twait, r_trcd, r_trc;
    logic [CNT_W-1:0] r_tburst;
    logic [2:0]       r_tlat;
    logic             r_mode_err;
    logic             w_cmd_load;
    logic [CNT_W-1:0] w_cmd_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_trp   <= CNT_W'(TRP_DEF);
            r_twait <= CNT_W'(TWAIT_DEF);
            r_trcd  <= CNT_W'(TRCD_DEF);
            r_trc   <= CNT_W'(TRC_DEF);
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_TRP:   r_trp   <= cfg_data;
                CFG_TWAIT: r_twait <= cfg_data;
                CFG_TRCD:  r_trcd  <= cfg_data;
                default:   r_trc   <= cfg_data;
            endcase
        end
    end

    // Reserved burst codes keep the previous burst length and flag an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tburst   <= CNT_W'(1);
            r_tlat     <= 3'(CAS_OFFSET);
            r_mode_err <= 1'b0;
        end else begin
            r_mode_err <= 1'b0;
            if (mode_we) begin
                r_tlat <= {1'b0, prog_data[5:4]} + 3'(CAS_OFFSET);
                case (prog_data[2:0])
                    3'd0, 3'd1, 3'd2, 3'd3: r_tburst <= CNT_W'(1) << prog_data[1:0];
                    BL_FULL:                r_tburst <= '1;
                    default:                r_mode_err <= 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        w_cmd_load = load_req;
        w_cmd_val  = '0;
        case (load_sel)
            LD_TRP:    w_cmd_val = r_trp;
            LD_TWAIT:  w_cmd_val = r_twait;
            LD_TCAS:   w_cmd_val = CNT_W'(r_tlat);
            LD_TBURST: w_cmd_val = r_tburst;
            LD_TRCD:   w_cmd_val = r_trcd;
            default:   w_cmd_load = 1'b0;
        endcase
    end

    sdram_down_counter #(.CNT_W(CNT_W)) u_cmd_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_cmd_load),
        .i_value (w_cmd_val),
        .o_count (count_out),
        .o_done  (cmd_done)
    );

    logic [NUM_BANKS-1:0] w_bank_done_unused;

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [CNT_W-1:0] w_cnt;
        sdram_down_counter #(.CNT_W(CNT_W)) u_bank_cnt (
            .clk     (clk),
            .reset   (reset),
            .i_load  (bank_load[gi]),
            .i_value (r_trc),
            .o_count (w_cnt),
            .o_done  (w_bank_done_unused[gi])
        );
        assign bank_busy[gi] = (w_cnt != '0);
    end

`ifdef SDRAM_TIMING_REFRESH_TIMER_EN
    logic [CNT_W-1:0] w_ref_cnt;
    logic             w_ref_done_unused;
    logic             r_ref_req;
    logic             w_ref_expire;

    // Expiry is the 1->0 step; the counter then reloads from zero.
    assign w_ref_expire = (w_ref_cnt == CNT_W'(1));

    sdram_down_counter #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(TREF_DEF))) u_ref_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_ref_cnt == '0),
        .i_value (CNT_W'(TREF_DEF)),
        .o_count (w_ref_cnt),
        .o_done  (w_ref_done_unused)
    );

    always_ff @(posedge clk) begin
        if (reset)             r_ref_req <= 1'b0;
        else if (w_ref_expire) r_ref_req <= 1'b1;
        else if (ref_ack)      r_ref_req <= 1'b0;
    end

    assign ref_req = r_ref_req;
`else
    logic w_ref_ack_unused;
    assign w_ref_ack_unused = ref_ack;
    assign ref_req          = 1'b0;
`endif

    logic [4:0] w_prog_unused;
    assign w_prog_unused = {prog_data[CNT_W-1:6], prog_data[3]};

    assign tburst   = r_tburst;
    assign tlat     = r_tlat;
    assign mode_err = r_mode_err;

endmodule

// File: tb/tb_sdram_timing_engine.sv
// Directed self-checking bench for sdram_timing_engine.
module tb_sdram_timing_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode_we;
    logic [9:0]  prog_data;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [9:0]  cfg_data;
    logic        load_req;
    logic [2:0]  load_sel;
    logic [3:0]  bank_load;
    logic [9:0]  count_out;
    logic        cmd_done;
    logic [9:0]  tburst;
    logic [2:0]  tlat;
    logic [3:0]  bank_busy;
    logic        mode_err;
    logic        ref_req;
    logic        ref_ack;

    int n_chk = 0;
    int n_err = 0;

    sdram_timing_engine #(.TREF_DEF(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_we   (mode_we),
        .prog_data (prog_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .load_req  (load_req),
        .load_sel  (load_sel),
        .bank_load (bank_load),
        .count_out (count_out),
        .cmd_done  (cmd_done),
        .tburst    (tburst),
        .tlat      (tlat),
        .bank_busy (bank_busy),
        .mode_err  (mode_err),
        .ref_req   (ref_req),
        .ref_ack   (ref_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int exp_cnt, input logic exp_done, input string tag);
        chk({tag, ".cnt"}, 32'(count_out), 32'(exp_cnt));
        chk({tag, ".done"}, 32'(cmd_done), 32'(exp_done));
    endtask

    initial begin
        reset = 1'b1; mode_we = 0; prog_data = '0; cfg_we = 0; cfg_addr = '0;
        cfg_data = '0; load_req = 0; load_sel = '0; bank_load = '0; ref_ack = 0;
        tick(); tick();
        reset = 1'b0;
        chk("rst.cnt", 32'(count_out), 0);
        chk("rst.done", 32'(cmd_done), 0);
        chk("rst.busy", 32'(bank_busy), 0);
        chk("rst.merr", 32'(mode_err), 0);
        chk("rst.tburst", 32'(tburst), 1);
        chk("rst.tlat", 32'(tlat), 2);
        chk("rst.ref", 32'(ref_req), 0);

`ifdef SDRAM_TIMING_REFRESH_TIMER_EN
        // Counter sits at 10 after reset; the 1->0 step lands on the tenth edge.
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("ref.pre", 32'(ref_req), 0);
        end
        tick();
        chk("ref.rise", 32'(ref_req), 1);
        for (int i = 11; i <= 24; i++) begin
            tick();
            chk("ref.hold", 32'(ref_req), 1);
        end
        ref_ack = 1'b1; tick(); ref_ack = 1'b0;
        chk("ref.ack", 32'(ref_req), 0);
        reset = 1'b1; tick(); reset = 1'b0;
`else
        ref_ack = 1'b1; tick(); ref_ack = 1'b0;
        chk("ref.off", 32'(ref_req), 0);
`endif

        // tRP default 3
        load_req = 1; load_sel = 3'd0; tick(); load_req = 0;
        cmd(3, 0, "trp3");
        tick(); cmd(2, 0, "trp2");
        tick(); cmd(1, 0, "trp1");
        tick(); cmd(0, 1, "trp0");
        tick(); cmd(0, 0, "trp_sat");

        // BL=8, CAS code 2
        mode_we = 1; prog_data = 10'h023; tick(); mode_we = 0;
        chk("m23.tburst", 32'(tburst), 8);
        chk("m23.tlat", 32'(tlat), 4);
        chk("m23.merr", 32'(mode_err), 0);
        load_req = 1; load_sel = 3'd3; tick(); load_req = 0;
        cmd(8, 0, "bst8");
        for (int i = 7; i >= 1; i--) begin
            tick(); cmd(i, 0, "bst");
        end
        tick(); cmd(0, 1, "bst0");

        // tCAS load uses tlat
        load_req = 1; load_sel = 3'd2; tick(); load_req = 0;
        cmd(4, 0, "tcas");

        // Reserved BL code: error pulse, burst unchanged, tlat still updated
        mode_we = 1; prog_data = 10'h015; tick(); mode_we = 0;
        chk("m15.merr", 32'(mode_err), 1);
        chk("m15.tburst", 32'(tburst), 8);
        chk("m15.tlat", 32'(tlat), 3);
        tick();
        chk("m15.merr_off", 32'(mode_err), 0);

        mode_we = 1; prog_data = 10'h007; tick(); mode_we = 0;
        chk("m07.tburst", 32'(tburst), 1023);
        chk("m07.tlat", 32'(tlat), 2);

        // Same-cycle mode write and load: old tburst (1023) is loaded
        mode_we = 1; prog_data = 10'h001; load_req = 1; load_sel = 3'd3; tick();
        mode_we = 0; load_req = 0;
        chk("old.cnt", 32'(count_out), 1023);
        chk("old.tburst", 32'(tburst), 2);

        // Load of an ignored select keeps counting
        load_req = 1; load_sel = 3'd5; tick(); load_req = 0;
        chk("sel5", 32'(count_out), 1022);

        // Load of zero from a reprogrammed tRCD: no done pulse
        cfg_we = 1; cfg_addr = 2'd2; cfg_data = 10'd0; tick(); cfg_we = 0;
        load_req = 1; load_sel = 3'd4; tick(); load_req = 0;
        cmd(0, 0, "ld0");
        tick(); cmd(0, 0, "ld0b");

        // tRC=5, banks 0 and 2
        cfg_we = 1; cfg_addr = 2'd3; cfg_data = 10'd5; tick(); cfg_we = 0;
        bank_load = 4'b0101; tick(); bank_load = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            chk("bank5", 32'(bank_busy), 32'h5);
            tick();
        end
        chk("bank5_end", 32'(bank_busy), 0);

        // Reload bank 0 with 3 left: bank 0 runs 5 more, bank 2 finishes at 2
        bank_load = 4'b0101; tick(); bank_load = 4'b0000;
        tick(); tick();
        bank_load = 4'b0001; tick(); bank_load = 4'b0000;
        chk("rl.a", 32'(bank_busy), 32'h5);
        tick(); chk("rl.b", 32'(bank_busy), 32'h5);
        tick(); chk("rl.c", 32'(bank_busy), 32'h1);
        tick(); tick();
        chk("rl.d", 32'(bank_busy), 32'h1);
        tick(); chk("rl.e", 32'(bank_busy), 0);

        // Same-cycle cfg write and bank load: old tRC (5) is used
        cfg_we = 1; cfg_addr = 2'd3; cfg_data = 10'd2; bank_load = 4'b0010; tick();
        cfg_we = 0; bank_load = 4'b0000;
        tick(); tick(); tick(); tick();
        chk("oldtrc.busy", 32'(bank_busy), 32'h2);
        tick(); chk("oldtrc.end", 32'(bank_busy), 0);
        bank_load = 4'b1000; tick(); bank_load = 4'b0000;
        tick(); chk("newtrc.busy", 32'(bank_busy), 32'h8);
        tick(); chk("newtrc.end", 32'(bank_busy), 0);

        // Reload mid-count at 1 restarts with no done
        load_req = 1; load_sel = 3'd1; tick(); load_req = 0;
        tick(); tick();
        cmd(1, 0, "rlc1");
        load_req = 1; tick(); load_req = 0;
        cmd(3, 0, "rlc3");
        tick(); cmd(2, 0, "rlc2");

        // Reset mid-count clears everything and restores defaults
        bank_load = 4'b1111; tick(); bank_load = 4'b0000;
        reset = 1; tick(); reset = 0;
        cmd(0, 0, "rst2");
        chk("rst2.busy", 32'(bank_busy), 0);
        chk("rst2.tburst", 32'(tburst), 1);
        chk("rst2.tlat", 32'(tlat), 2);
        load_req = 1; load_sel = 3'd3; tick(); load_req = 0;
        cmd(1, 0, "rst2.bl1");
        tick(); cmd(0, 1, "rst2.bl0");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
